mux_reduce_pipe: RTL and testbench
==================================

# mux_reduce_pipe

Parametrised, pipelined reduction gate that folds a `WIDTH`-bit vector to one bit with a runtime-selectable operation: AND, OR, XOR or NAND. Every 2-input gate in the tree is built only from 2:1 `mux` cells and the constants 0/1, with no behavioural `&`, `|`, `^` or `~` on data. A register stage follows every tree level, and a valid bit travels alongside the data. It generalises the single mux-based AND gate to arbitrary width, four modes and full-throughput streaming. It sits in the combinational-logic exercise set as the first sequential user of the shared `mux` cell.

## Interface

Parameters:
- `WIDTH`, default 8: number of input bits; legal range 1..64.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `in_valid`, input, 1: `in_data` and `in_mode` are valid this cycle.
- `in_data`, input, `WIDTH`: vector to reduce.
- `in_mode`, input, 2: 0 = AND, 1 = OR, 2 = XOR, 3 = NAND.
- `out_valid`, output, 1: `out_result` is valid this cycle.
- `out_result`, output, 1: reduction result.

## Operation

- Tree depth is `D = $clog2(WIDTH)`.
- Pipeline latency is `L = max(1, D)` cycles, from the edge that samples `in_valid=1` to the cycle in which `out_valid=1`.
- Padding: the input is padded to `2**D` bits with the identity of the sampled mode.
  - AND and NAND pad with 1.
  - OR and XOR pad with 0.
- Gate cell for operand bits `a` and `b`, using muxes only:
  - AND: `mux(0, a, b)`.
  - OR: `mux(a, 1, b)`.
  - XOR: `mux(a, na, b)`, where `na = mux(1, 0, a)`.
  - NAND: computed as AND through the whole tree; the final stage inverts with `mux(1, 0, x)`.
- Mode selection inside the cell is itself a 4:1 built from three `mux` instances.
- The mode is captured with the data and carried down the pipeline per item. Consecutive items may use different modes with no bubble.
- `WIDTH = 1`: no tree levels.
  - The single register stage outputs `in_data[0]` for AND, OR and XOR.
  - It outputs the inverse of `in_data[0]` for NAND.
- Throughput is one item per cycle. There is no backpressure and no stall input.
- Bubbles (`in_valid = 0`) propagate as `out_valid = 0`.
- A stage's data and mode registers load only when that stage's incoming valid is 1. When it is 0 they hold, so `out_result` holds its last valid value while `out_valid = 0`.

## Timing

- Reset:
  - All stage valid bits are cleared to 0 on the first rising edge with `rst = 1`.
  - All data registers and `out_result` are cleared to 0.
  - Mode registers are cleared to AND.
  - `out_valid = 0` and `out_result = 0` in the cycle after that edge.
- Reset mid-operation:
  - Every item in flight is discarded. No `out_valid` pulse for those items appears after `rst` is released.
  - An item presented in the same cycle as `rst = 1` is also discarded.
- The first item accepted in the cycle after `rst` falls emerges exactly `L` cycles later.
- There is no combinational path from any input to any output.
- X on `in_data` while `in_valid = 0` must not reach `out_result`.

## Structure

- Package `mux_reduce_pkg`:
  - `typedef enum logic [1:0] { RED_AND, RED_OR, RED_XOR, RED_NAND } red_mode_t;`
  - Function `red_identity(red_mode_t)`, which returns the padding bit.
- Sub-module `mux_gate2`:
  - Ports: `a`, `b`, `mode` (type `red_mode_t`), output `y`.
  - Built from `mux` instances only.
  - Used `2**D − 1` times in the tree. NAND behaves as AND inside this cell.
- Top level contains:
  - The padding logic.
  - A generate loop over tree levels, with a per-level data, mode and valid register.
  - The final NAND inversion mux.
- The existing `mux` cell is reused unchanged.

## Test plan

All scenarios use `WIDTH = 5`, so `D = 3` and `L = 3`, unless stated otherwise.

1. **Reset:** hold `rst = 1` for 2 cycles with random inputs and `in_valid = 1` → `out_valid = 0` and `out_result = 0` throughout, and for 3 cycles after release.
2. **Single items:**
   - AND on `5'b11111` → `out_result = 1`, `out_valid = 1` exactly 3 cycles after sampling.
   - AND on `5'b11011` → 0.
   - OR on `5'b00000` → 0.
   - OR on `5'b00100` → 1.
3. **Back-to-back mixed modes** on consecutive cycles: OR `5'b00000`, XOR `5'b10110`, NAND `5'b11111`, XOR `5'b10000` → outputs 0, 1, 0, 1 on 4 consecutive cycles, all with `out_valid = 1`. This also checks padding: XOR pads with 0 and NAND with 1.
4. **Bubbles:** item AND `5'b11111`, then 2 cycles with `in_valid = 0` and `in_data = 'x`, then OR `5'b00001` → `out_valid` pattern 1, 0, 0, 1; `out_result` holds 1 through the bubbles, then 1.
5. **Mid-flight reset:** inject XOR `5'b00001` and AND `5'b11111` on consecutive cycles, then assert `rst` for 1 cycle on the next cycle → no `out_valid` pulse for either item; the next item accepted after release appears 3 cycles later.
6. **Exhaustive sweep:** `WIDTH = 1` and `WIDTH = 8`, all modes, all inputs (random 1000 items for 8) → compared against a reference model using `&`, `|`, `^` delayed by `L` (1 and 3 respectively).

Source files
------------

// File: rtl/mux_reduce_pipe_pkg.sv
// Shared types and helpers for the mux-only pipelined reduction gate.
package mux_reduce_pkg;

  typedef enum logic [1:0] {
    RED_AND  = 2'd0,
    RED_OR   = 2'd1,
    RED_XOR  = 2'd2,
    RED_NAND = 2'd3
  } red_mode_t;

  // Padding bit that leaves the reduction unchanged; NAND reduces as AND until the last stage.
  function automatic logic red_identity(input red_mode_t mode);
    logic id_bit;
    case (mode)
      RED_AND, RED_NAND: id_bit = 1'b1;
      RED_OR, RED_XOR:   id_bit = 1'b0;
      default:           id_bit = 1'b0;
    endcase
    return id_bit;
  endfunction

endpackage

// File: rtl/mux.sv
// Shared 2:1 multiplexer cell: y = sel ? d1 : d0.
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_reduce_pipe_gate2.sv
// Two-input mode-selectable gate (AND/OR/XOR, NAND treated as AND) built only from mux cells.
import mux_reduce_pkg::*;

module mux_gate2 (
  input  logic      a,
  input  logic      b,
  input  red_mode_t mode,
  output logic      y
);

  logic       na_s;
  logic       and_s;
  logic       or_s;
  logic       xor_s;
  logic       sel_lo_s;
  logic       sel_hi_s;
  logic [1:0] mode_bits_s;

  assign mode_bits_s = mode;

  mux u_na  (.d0(1'b1), .d1(1'b0), .sel(a), .y(na_s));
  mux u_and (.d0(1'b0), .d1(a),    .sel(b), .y(and_s));
  mux u_or  (.d0(a),    .d1(1'b1), .sel(b), .y(or_s));
  mux u_xor (.d0(a),    .d1(na_s), .sel(b), .y(xor_s));

  // 4:1 mode select: low pair picks AND/OR, high pair picks XOR/AND(NAND).
  mux u_sel_lo (.d0(and_s),    .d1(or_s),     .sel(mode_bits_s[0]), .y(sel_lo_s));
  mux u_sel_hi (.d0(xor_s),    .d1(and_s),    .sel(mode_bits_s[0]), .y(sel_hi_s));
  mux u_sel    (.d0(sel_lo_s), .d1(sel_hi_s), .sel(mode_bits_s[1]), .y(y));

endmodule

// File: rtl/mux_reduce_pipe.sv
// Pipelined WIDTH-to-1 reduction (AND/OR/XOR/NAND) with a register stage after every tree level.
import mux_reduce_pkg::*;

module mux_reduce_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  output logic             out_result
);

  localparam int D = $clog2(WIDTH);
  localparam int P = 1 << D;

  red_mode_t  in_mode_s;
  logic [P-1:0] pad_s;
  logic       fin_data_s;
  red_mode_t  fin_mode_s;
  logic       fin_vld_s;
  logic       is_nand_s;
  logic       ninv_s;
  logic       res_s;

  assign in_mode_s = red_mode_t'(in_mode);

  // Fill the unused upper leaves with the identity of the incoming mode.
  always_comb begin
    pad_s              = {P{red_identity(in_mode_s)}};
    pad_s[WIDTH-1:0]   = in_data;
  end

  generate
    if (D == 0) begin : g_flat
      logic      data_q;
      logic      data_d;
      red_mode_t mode_q;
      logic      vld_q;

      assign data_d = pad_s[0];

      // Single stage: valid always follows input, data/mode load only on valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          data_q <= 1'b0;
          mode_q <= RED_AND;
        end else begin
          vld_q <= in_valid;
          if (in_valid) begin
            data_q <= data_d;
            mode_q <= in_mode_s;
          end
        end
      end

      assign fin_data_s = data_q;
      assign fin_mode_s = mode_q;
      assign fin_vld_s  = vld_q;
    end else begin : g_tree
      // Level l results live at tree_s[P - (P >> l) +: (P >> (l+1))].
      logic [P-2:0] tree_s;
      red_mode_t    mode_s [D];
      logic [D-1:0] vld_s;

      for (genvar l = 0; l < D; l++) begin : g_lvl
        localparam int NI    = P >> l;
        localparam int NO    = NI >> 1;
        localparam int OFF_O = P - NI;
        localparam int OFF_I = P - 2 * NI;

        logic [NI-1:0] lin_s;
        red_mode_t     lmode_s;
        logic          lvld_s;
        logic [NO-1:0] data_d;
        logic [NO-1:0] data_q;
        red_mode_t     mode_q;
        logic          vld_q;

        if (l == 0) begin : g_head
          assign lin_s   = pad_s;
          assign lmode_s = in_mode_s;
          assign lvld_s  = in_valid;
        end else begin : g_body
          assign lin_s   = tree_s[OFF_I +: NI];
          assign lmode_s = mode_s[l-1];
          assign lvld_s  = vld_s[l-1];
        end

        for (genvar j = 0; j < NO; j++) begin : g_gate
          mux_gate2 u_gate (
            .a    (lin_s[2*j]),
            .b    (lin_s[2*j+1]),
            .mode (lmode_s),
            .y    (data_d[j])
          );
        end

        // Level register: valid always advances, data/mode hold across bubbles.
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            mode_q <= RED_AND;
          end else begin
            vld_q <= lvld_s;
            if (lvld_s) begin
              data_q <= data_d;
              mode_q <= lmode_s;
            end
          end
        end

        assign tree_s[OFF_O +: NO] = data_q;
        assign mode_s[l]           = mode_q;
        assign vld_s[l]            = vld_q;
      end

      assign fin_data_s = tree_s[P-2];
      assign fin_mode_s = mode_s[D-1];
      assign fin_vld_s  = vld_s[D-1];
    end
  endgenerate

  // NAND travelled as AND through the tree; invert it at the output.
  assign is_nand_s = (fin_mode_s == RED_NAND);

  mux u_ninv (.d0(1'b1),       .d1(1'b0),   .sel(fin_data_s), .y(ninv_s));
  mux u_fin  (.d0(fin_data_s), .d1(ninv_s), .sel(is_nand_s),  .y(res_s));

  assign out_valid  = fin_vld_s;
  assign out_result = res_s;

endmodule

// File: tb/tb_mux_reduce_pipe.sv
// Directed table plus randomized scoreboard bench for mux_reduce_pipe at WIDTH 1, 5 and 8.
module tb_mux_reduce_pipe;

  logic clk;
  logic rst;

  logic       v1, v5, v8;
  logic [0:0] d1;
  logic [4:0] d5;
  logic [7:0] d8;
  logic [1:0] m1, m5, m8;
  logic       ov1, ov5, ov8;
  logic       or1, or5, or8;

  int total;
  int bad;
  int cyc;

  typedef struct {
    int id;
    int due;
    bit r;
  } item_t;

  item_t pend[$];
  bit    hold[3];

  typedef struct {
    bit         rst;
    bit         vld;
    logic [1:0] mode;
    logic [4:0] data;
    bit         ev;
    bit         er;
  } vec_t;

  vec_t tbl[30];

  mux_reduce_pipe #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_mode(m1),
    .out_valid(ov1), .out_result(or1)
  );

  mux_reduce_pipe #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_mode(m5),
    .out_valid(ov5), .out_result(or5)
  );

  mux_reduce_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .in_mode(m8),
    .out_valid(ov8), .out_result(or8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  // Reduction straight from the mode definition over the first width bits.
  function automatic bit ref_red(input logic [1:0] mode, input logic [63:0] data, input int width);
    logic [63:0] mask;
    logic [63:0] d;
    bit all1;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    d    = data & mask;
    all1 = (d == mask);
    case (mode)
      2'd0:    return all1;
      2'd1:    return |d;
      2'd2:    return ^d;
      default: return !all1;
    endcase
  endfunction

  // One clock: scoreboard absorbs sampled items, then every DUT output is checked.
  task automatic tick();
    bit ev;
    logic av, ar;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      hold = '{1'b0, 1'b0, 1'b0};
    end else begin
      if (v1) pend.push_back('{0, cyc,     ref_red(m1, 64'(d1), 1)});
      if (v5) pend.push_back('{1, cyc + 2, ref_red(m5, 64'(d5), 5)});
      if (v8) pend.push_back('{2, cyc + 2, ref_red(m8, 64'(d8), 8)});
    end
    #1;
    for (int id = 0; id < 3; id++) begin
      ev = 1'b0;
      for (int k = pend.size() - 1; k >= 0; k--) begin
        if (pend[k].id == id && pend[k].due == cyc) begin
          ev       = 1'b1;
          hold[id] = pend[k].r;
          pend.delete(k);
        end
      end
      case (id)
        0:       begin av = ov1; ar = or1; end
        1:       begin av = ov5; ar = or5; end
        default: begin av = ov8; ar = or8; end
      endcase
      check($sformatf("model_w%0d_valid", id), av, ev);
      check($sformatf("model_w%0d_result", id), ar, hold[id]);
    end
    cyc++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    hold  = '{1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    v1 = 1'b0; v5 = 1'b0; v8 = 1'b0;
    d1 = 1'b0; d5 = 5'd0; d8 = 8'd0;
    m1 = 2'd0; m5 = 2'd0; m8 = 2'd0;

    // rst, vld, mode, data, expected out_valid, expected out_result (3-cycle latency)
    tbl[0]  = '{1'b1, 1'b1, 2'd2, 5'b10110, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'd3, 5'b01101, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 5'b11111, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 5'b11011, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 5'b00000, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 2'd1, 5'b00100, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 2'd1, 5'b00000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 5'b10110, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 2'd3, 5'b11111, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'd2, 5'b10000, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 2'd0, 5'b11111, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 2'd0, 5'bxxxxx, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 2'd0, 5'bxxxxx, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 2'd1, 5'b00001, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 1'b1, 2'd2, 5'b00001, 1'b0, 1'b1};
    tbl[24] = '{1'b0, 1'b1, 2'd0, 5'b11111, 1'b0, 1'b1};
    tbl[25] = '{1'b1, 1'b1, 2'd0, 5'b11111, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b1, 2'd1, 5'b00100, 1'b0, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 1'b0};
    tbl[28] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b1, 1'b1};
    tbl[29] = '{1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 1'b1};

    for (int i = 0; i < 30; i++) begin
      rst = tbl[i].rst;
      v5  = tbl[i].vld;
      m5  = tbl[i].mode;
      d5  = tbl[i].data;
      tick();
      check($sformatf("tbl%0d_valid", i), ov5, tbl[i].ev);
      check($sformatf("tbl%0d_result", i), or5, tbl[i].er);
    end

    // Random streaming on all widths; WIDTH=1 starts with its full mode x input sweep.
    for (int c = 0; c < 1100; c++) begin
      rst = (c == 500);
      if (c < 8) begin
        v1 = 1'b1;
        m1 = 2'(c >> 1);
        d1 = 1'(c & 1);
      end else begin
        v1 = ($urandom_range(0, 3) != 0);
        m1 = 2'($urandom_range(0, 3));
        d1 = 1'($urandom_range(0, 1));
      end
      v5 = ($urandom_range(0, 4) != 0);
      m5 = 2'($urandom_range(0, 3));
      d5 = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
      v8 = ($urandom_range(0, 9) != 0);
      m8 = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       d8 = 8'hFF;
        1:       d8 = 8'h00;
        default: d8 = 8'($urandom);
      endcase
      tick();
    end

    rst = 1'b0;
    v1 = 1'b0; v5 = 1'b0; v8 = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
